// File: rtl/oam_dma_engine.sv
// oam_dma_engine: on an FF46 write, copies LEN bytes from BRAM page src_page (port B) into OAM.
// Build option: define DMA_STARTUP_DELAY_EN to add one byte period of idle time before the first read.
module oam_dma_engine #(
    parameter int LEN         = 160,
    parameter int BYTE_PERIOD = 4,
    parameter int ADDR_W      = 15
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [7:0]        src_page,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [7:0]        dinb,
    input  logic [7:0]        doutb,
    output logic              oam_we,
    output logic [7:0]        oam_addr,
    output logic [7:0]        oam_din,
    output logic              busy,
    output logic              cpu_block,
    output logic              done
);
    localparam int               CNT_W    = $clog2(BYTE_PERIOD + 1);
    localparam logic [7:0]       LAST_IDX = 8'(LEN - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'((BYTE_PERIOD > 2) ? BYTE_PERIOD - 3 : 0);
    localparam bit               NO_GAP   = (BYTE_PERIOD == 2);
`ifdef DMA_STARTUP_DELAY_EN
    localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(BYTE_PERIOD - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_GAP, S_FIN
`ifdef DMA_STARTUP_DELAY_EN
        , S_DLY
`endif
    } state_t;

    state_t           state;
    logic [7:0]       idx;
    logic [7:0]       page;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // Page bit 7 falls off the top: the BRAM is only 32 KiB, so high pages alias.
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [7:0] pg, input logic [7:0] ix);
        return ADDR_W'({pg, ix});
    endfunction

    assign web       = 1'b0;
    assign dinb      = 8'h00;
    assign cpu_block = busy;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state    <= S_IDLE;
            enb      <= 1'b0;
            oam_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            addrb    <= '0;
            oam_addr <= '0;
            oam_din  <= '0;
            idx      <= '0;
            page     <= '0;
            cnt      <= '0;
            last     <= 1'b0;
        end else begin
            enb    <= 1'b0;
            oam_we <= 1'b0;
            done   <= 1'b0;
            // A new FF46 write wins in every state; an in-flight copy is dropped silently,
            // but one caught in FIN has already finished and still reports done.
            if (start) begin
                page <= src_page;
                idx  <= '0;
                cnt  <= '0;
                last <= 1'b0;
                busy <= 1'b1;
                done <= (state == S_FIN);
`ifdef DMA_STARTUP_DELAY_EN
                state <= S_DLY;
`else
                state <= S_RD;
                enb   <= 1'b1;
                addrb <= rd_addr(src_page, 8'd0);
`endif
            end else begin
                case (state)
                    S_IDLE: ;
`ifdef DMA_STARTUP_DELAY_EN
                    S_DLY: begin
                        if (cnt == DLY_END) begin
                            state <= S_RD;
                            enb   <= 1'b1;
                            addrb <= rd_addr(page, idx);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    S_RD: begin
                        cnt   <= '0;
                        state <= S_WR;
                    end
                    S_WR: begin
                        oam_din  <= doutb;
                        oam_addr <= idx;
                        oam_we   <= 1'b1;
                        // The final byte still sits out its gap, keeping start->done at LEN*BYTE_PERIOD+1.
                        if (idx == LAST_IDX) begin
                            last  <= 1'b1;
                            state <= NO_GAP ? S_FIN : S_GAP;
                        end else begin
                            idx <= idx + 8'd1;
                            if (NO_GAP) begin
                                state <= S_RD;
                                enb   <= 1'b1;
                                addrb <= rd_addr(page, idx + 8'd1);
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (cnt == GAP_END) begin
                            if (last) begin
                                state <= S_FIN;
                            end else begin
                                state <= S_RD;
                                enb   <= 1'b1;
                                addrb <= rd_addr(page, idx);
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_FIN: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed scoreboard bench for oam_dma_engine: a default instance (160 B, period 4)
// and a 256 B / period 2 instance sharing one BRAM model.
module tb_oam_dma_engine;
    localparam int LEN  = 160;
    localparam int BP   = 4;
    localparam int LEN2 = 256;
    localparam int BP2  = 2;

    logic clka = 1'b0;
    logic rsta = 1'b0;
    always #5 clka = ~clka;

    logic        start = 1'b0, start2 = 1'b0;
    logic [7:0]  src_page = '0, src_page2 = '0;
    logic        enb, web, oam_we, busy, cpu_block, done;
    logic [14:0] addrb;
    logic [7:0]  dinb, oam_addr, oam_din;
    logic [7:0]  doutb = '0;
    logic        enb2, web2, oam_we2, busy2, cpu_block2, done2;
    logic [14:0] addrb2;
    logic [7:0]  dinb2, oam_addr2, oam_din2;
    logic [7:0]  doutb2 = '0;

    oam_dma_engine #(.LEN(LEN), .BYTE_PERIOD(BP), .ADDR_W(15)) dut (
        .clka(clka), .rsta(rsta), .start(start), .src_page(src_page),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_din(oam_din),
        .busy(busy), .cpu_block(cpu_block), .done(done)
    );

    oam_dma_engine #(.LEN(LEN2), .BYTE_PERIOD(BP2), .ADDR_W(15)) dut2 (
        .clka(clka), .rsta(rsta), .start(start2), .src_page(src_page2),
        .enb(enb2), .web(web2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2),
        .oam_we(oam_we2), .oam_addr(oam_addr2), .oam_din(oam_din2),
        .busy(busy2), .cpu_block(cpu_block2), .done(done2)
    );

    logic [7:0] mem     [0:32767];
    logic [7:0] oam_mem [0:255];

    always @(posedge clka) begin
        if (enb)  doutb  <= mem[addrb];
        if (enb2) doutb2 <= mem[addrb2];
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int t_start = 0;

    logic [15:0] exp_q[$], next_q[$], exp2_q[$];
    bit          swap_pending = 1'b0;
    int          done_q[$], done2_q[$];
    logic [14:0] enb_addr_q[$], enb2_addr_q[$];
    int          enb_cyc_q[$], enb2_cyc_q[$];
    int          bad_tie = 0, busy_low = 0;
    bit          track_busy = 1'b0, keep_track = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Output monitor: scoreboard pops per OAM write, plus logs for later checks.
    always @(negedge clka) begin
        logic [15:0] e;
        if (!rsta) begin
            if (oam_we) begin
                oam_mem[oam_addr] = oam_din;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("oam_write", {oam_addr, oam_din}, e);
            end
            if (swap_pending) begin
                exp_q = next_q;
                next_q.delete();
                swap_pending = 1'b0;
            end
            if (done && !keep_track) track_busy = 1'b0;
            if (track_busy && !busy) busy_low++;
            if (done) done_q.push_back(cyc);
            if (enb) begin
                enb_addr_q.push_back(addrb);
                enb_cyc_q.push_back(cyc);
            end
            if (web !== 1'b0 || dinb !== 8'h00 || cpu_block !== busy) bad_tie++;
            if (oam_we2) begin
                e = (exp2_q.size() > 0) ? exp2_q.pop_front() : 16'hxxxx;
                check("oam2_write", {oam_addr2, oam_din2}, e);
            end
            if (done2) done2_q.push_back(cyc);
            if (enb2) begin
                enb2_addr_q.push_back(addrb2);
                enb2_cyc_q.push_back(cyc);
            end
            if (web2 !== 1'b0 || dinb2 !== 8'h00 || cpu_block2 !== busy2) bad_tie++;
        end
    end

    function automatic int lat(input int k, input int t);
        return (done_q.size() > k) ? done_q[k] - t - 1 : -1;
    endfunction

    task automatic clear_logs();
        done_q.delete();
        enb_addr_q.delete();
        enb_cyc_q.delete();
        busy_low   = 0;
        keep_track = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] p);
        logic [14:0] a;
        next_q.delete();
        for (int i = 0; i < LEN; i++) begin
            a = {p[6:0], 8'(i)};
            next_q.push_back({8'(i), mem[a]});
        end
        swap_pending = 1'b1;
        start        = 1'b1;
        src_page     = p;
        t_start      = cyc;
        @(posedge clka); #1;
        start      = 1'b0;
        track_busy = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clka); #1;
            k++;
        end
        check("done_timeout", done_q.size() >= n, 1);
    endtask

    task automatic check_oam(input string tag, input logic [7:0] p);
        int bad = 0;
        logic [14:0] a;
        for (int i = 0; i < LEN; i++) begin
            a = {p[6:0], 8'(i)};
            if (oam_mem[i] !== mem[a]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bram_side"}, {enb, web, addrb, dinb}, '0);
        check({tag, "_oam_side"}, {oam_we, oam_addr, oam_din, busy, cpu_block, done}, '0);
    endtask

    initial begin
        logic [14:0] av;
        int bad, k, t2, ta, tb;

        for (int a = 0; a < 32768; a++) begin
            av     = 15'(a);
            mem[a] = (av[7:0] * 8'd3) ^ {1'b0, av[14:8]};
        end
        for (int i = 0; i < LEN; i++) mem[15'h1200 + 15'(i)] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

        // Reset state
        #2 rsta = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(posedge clka);
        #1 rsta = 1'b0;
        @(posedge clka); #1;

        // Full copy of page 0x12
        clear_logs();
        pulse(8'h12);
        wait_done(1, 1000);
        check("t1_latency", lat(0, t_start), LEN * BP + 1);
        check("t1_first_rd", (enb_cyc_q.size() > 0) ? enb_cyc_q[0] - t_start - 1 : -1, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_busy_held", busy_low, 0);
        check("t1_enb_count", enb_addr_q.size(), LEN);
        bad = 0;
        for (int i = 0; i < enb_addr_q.size(); i++) begin
            if (enb_addr_q[i] !== 15'h1200 + 15'(i)) bad++;
            if (i > 0 && enb_cyc_q[i] - enb_cyc_q[i-1] != BP) bad++;
        end
        check("t1_enb_seq", bad, 0);
        bad = 0;
        for (int i = 0; i < LEN; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
        check("t1_oam_5a", bad, 0);
        check("t1_idle_busy", busy, 0);

        // Restart mid-copy at byte 50
        clear_logs();
        pulse(8'h12);
        repeat (199) @(posedge clka);
        #1 pulse(8'h34);
        wait_done(1, 1000);
        repeat (20) @(posedge clka);
        #1 check("t3_single_done", done_q.size(), 1);
        check("t3_latency", lat(0, t_start), LEN * BP + 1);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_busy_held", busy_low, 0);
        check_oam("t3_oam_page34", 8'h34);

        // Reset in the middle of a copy, then a clean copy
        clear_logs();
        pulse(8'h12);
        repeat (319) @(posedge clka);
        #1 rsta = 1'b1;
        #1 check_zero("t4_midreset");
        swap_pending = 1'b0;
        exp_q.delete();
        next_q.delete();
        track_busy = 1'b0;
        repeat (3) @(posedge clka);
        #1 rsta = 1'b0;
        check("t4_no_done", done_q.size(), 0);
        @(posedge clka); #1;
        pulse(8'h01);
        wait_done(1, 1000);
        check("t4_latency", lat(0, t_start), LEN * BP + 1);
        check("t4_sb_empty", exp_q.size(), 0);
        check_oam("t4_oam_page01", 8'h01);

        // 256 bytes at period 2 from page 0xFF (aliases to 0x7F)
        for (int i = 0; i < LEN2; i++) exp2_q.push_back({8'(i), mem[{7'h7F, 8'(i)}]});
        start2    = 1'b1;
        src_page2 = 8'hFF;
        t2        = cyc;
        @(posedge clka); #1;
        start2 = 1'b0;
        k = 0;
        while (done2_q.size() == 0 && k < 2000) begin
            @(posedge clka); #1;
            k++;
        end
        check("t5_latency", (done2_q.size() > 0) ? done2_q[0] - t2 - 1 : -1, LEN2 * BP2 + 1);
        check("t5_enb_count", enb2_addr_q.size(), LEN2);
        check("t5_first_addr", (enb2_addr_q.size() > 0) ? enb2_addr_q[0] : 15'h0, 15'h7F00);
        check("t5_last_addr", (enb2_addr_q.size() > 0) ? enb2_addr_q[$] : 15'h0, 15'h7FFF);
        bad = 0;
        for (int i = 1; i < enb2_addr_q.size(); i++) begin
            if (enb2_addr_q[i] !== enb2_addr_q[i-1] + 15'd1) bad++;
            if (enb2_cyc_q[i] - enb2_cyc_q[i-1] != BP2) bad++;
        end
        check("t5_enb_seq", bad, 0);
        check("t5_sb_empty", exp2_q.size(), 0);

        // Start arriving exactly in the FIN cycle
        clear_logs();
        keep_track = 1'b1;
        pulse(8'h12);
        ta = t_start;
        repeat (LEN * BP) @(posedge clka);
        #1 pulse(8'h56);
        tb = t_start;
        wait_done(1, 100);
        keep_track = 1'b0;
        wait_done(2, 1000);
        repeat (10) @(posedge clka);
        #1 check("t6_done_count", done_q.size(), 2);
        check("t6_latency_a", lat(0, ta), LEN * BP + 1);
        check("t6_latency_b", lat(1, tb), LEN * BP + 1);
        check("t6_busy_held", busy_low, 0);
        check("t6_sb_empty", exp_q.size(), 0);
        check_oam("t6_oam_page56", 8'h56);

        check("tie_offs", bad_tie, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
